// File: rtl/alu_cmd_issuer.sv
// Command FIFO + sequencer that drives alu_8bit and returns its results.
// Optional ALU_CMD_STATS_EN adds accepted-response and error counters.
module alu_cmd_issuer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  input  logic        cmd_cin,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_cin,
  input  logic [15:0] alu_result,
  input  logic [7:0]  alu_rem,
  input  logic        alu_cout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [7:0]  rsp_rem,
  output logic        rsp_cout,
  output logic        rsp_err
`ifdef ALU_CMD_STATS_EN
  ,
  output logic [15:0] stat_ops,
  output logic [15:0] stat_errs
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int LW = $clog2(ALU_LAT + 1);

  typedef struct packed {
    logic [2:0] op;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    WAIT,
    RESP
  } state_t;

  state_t state, state_next;

  cmd_t          mem [FIFO_DEPTH];
  cmd_t          cur;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [LW-1:0] lat_cnt;

  logic push, pop, load, capture, reject, done;
  logic legal, bad;

  assign cmd_ready = (count != CW'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign rsp_valid = (state == RESP);

  always_comb begin
    legal = 1'b0;
    case (cur.op)
      3'b000, 3'b001,
      3'b101, 3'b110: legal = 1'b1;
      default:        legal = 1'b0;
    endcase
    bad = !legal || (cur.op == 3'b110 && cur.b == 8'd0);
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load       = 1'b0;
    capture    = 1'b0;
    reject     = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (bad) begin
          reject     = 1'b1;
          state_next = RESP;
        end else begin
          load       = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        // Extra cycle covers the ALU sampling edge after alu_* load.
        if (lat_cnt == LW'(ALU_LAT)) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{op: cmd_op, cin: cmd_cin,
                       a: cmd_a, b: cmd_b};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      cur        <= '0;
      lat_cnt    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_cin    <= 1'b0;
      rsp_result <= '0;
      rsp_rem    <= '0;
      rsp_cout   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        cur    <= mem[rd_ptr];
      end
      count <= count + CW'(push) - CW'(pop);
      if (load) begin
        alu_a   <= cur.a;
        alu_b   <= cur.b;
        alu_op  <= cur.op;
        alu_cin <= cur.cin;
        lat_cnt <= '0;
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt + 1'b1;
      end
      if (reject) begin
        rsp_result <= '0;
        rsp_rem    <= '0;
        rsp_cout   <= 1'b0;
        rsp_err    <= 1'b1;
      end else if (capture) begin
        rsp_result <= alu_result;
        rsp_rem    <= (cur.op == 3'b110) ? alu_rem : 8'd0;
        rsp_cout   <= alu_cout;
        rsp_err    <= 1'b0;
      end
    end
  end

`ifdef ALU_CMD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_ops  <= '0;
      stat_errs <= '0;
    end else if (done) begin
      if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 1'b1;
      if (rsp_err && stat_errs != 16'hFFFF)
        stat_errs <= stat_errs + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed + randomized bench for alu_cmd_issuer with a stand-in
// registered ALU and a response queue built from the opcode rules.
module tb_alu_cmd_issuer;

  localparam int DEPTH = 4;
  localparam int LAT   = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a, cmd_b;
  logic [2:0]  cmd_op;
  logic        cmd_cin;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_op;
  logic        alu_cin;
  logic [15:0] alu_result;
  logic [7:0]  alu_rem;
  logic        alu_cout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [7:0]  rsp_rem;
  logic        rsp_cout;
  logic        rsp_err;
`ifdef ALU_CMD_STATS_EN
  logic [15:0] stat_ops, stat_errs;
`endif

  alu_cmd_issuer #(.FIFO_DEPTH(DEPTH), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_cin(cmd_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_rem(alu_rem), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_rem(rsp_rem),
    .rsp_cout(rsp_cout), .rsp_err(rsp_err)
`ifdef ALU_CMD_STATS_EN
    , .stat_ops(stat_ops), .stat_errs(stat_errs)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in ALU, one registered stage. Junk rem/result on non-div and
  // reserved ops exposes missing rem forcing or reserved ops leaking through.
  logic signed [15:0] xa, xb;
  logic [8:0]         s9;
  always @(posedge clk) begin
    xa = 16'($signed(alu_a));
    xb = 16'($signed(alu_b));
    alu_rem <= 8'h5A;
    alu_cout <= 1'b0;
    case (alu_op)
      3'b000: begin
        s9 = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
        alu_result <= xa + xb + {15'd0, alu_cin};
        alu_cout <= s9[8];
      end
      3'b001: begin
        s9 = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_cin};
        alu_result <= xa - xb - {15'd0, alu_cin};
        alu_cout <= s9[8];
      end
      3'b101: alu_result <= xa * xb;
      3'b110: begin
        if (xb != 0) begin
          alu_result <= xa / xb;
          alu_rem <= 8'(xa % xb);
        end else begin
          alu_result <= 16'hFFFF;
        end
      end
      default: begin
        alu_result <= 16'hDEAD;
        alu_cout <= 1'b1;
      end
    endcase
  end

  // Expected response {err, cout, rem, result} from the opcode rules
  function automatic logic [25:0] model(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic [2:0] op,
                                        input logic cin);
    int sa, sb, ua, ub, c, r, m;
    logic e;
    sa = $signed(a); sb = $signed(b);
    ua = int'(a); ub = int'(b); c = int'(cin);
    r = 0; m = 0; e = 1'b0;
    model = '0;
    case (op)
      3'd0: begin
        r = sa + sb + c;
        model[24] = (ua + ub + c) > 255;
      end
      3'd1: begin
        r = sa - sb - c;
        model[24] = ua < (ub + c);
      end
      3'd5: r = sa * sb;
      3'd6: begin
        if (sb == 0) e = 1'b1;
        else begin
          r = sa / sb;
          m = sa % sb;
        end
      end
      default: e = 1'b1;
    endcase
    if (e) model = {1'b1, 25'd0};
    else begin
      model[15:0]  = r[15:0];
      model[23:16] = m[7:0];
    end
  endfunction

  int n_tests = 0;
  int n_fail  = 0;
  logic [25:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic push(input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] op, input logic cin);
    int t;
    cmd_valid = 1'b1;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_cin = cin;
    t = 0;
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("push_tmo", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    exp_q.push_back(model(a, b, op, cin));
  endtask

  task automatic collect(input string tag);
    int t;
    logic [25:0] e;
    t = 0;
    while (!rsp_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_tmo"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_qsz"}, {31'd0, exp_q.size() != 0}, 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    chk({tag, "_res"}, {16'd0, rsp_result}, {16'd0, e[15:0]});
    chk({tag, "_rem"}, {24'd0, rsp_rem}, {24'd0, e[23:16]});
    chk({tag, "_cout"}, {31'd0, rsp_cout}, {31'd0, e[24]});
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e[25]});
    repeat ($urandom_range(0, 2)) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  logic [18:0] alu_snap;
  logic [25:0] rsp_snap;
  int lat, stale;
`ifdef ALU_CMD_STATS_EN
  logic [15:0] errs0;
`endif

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_cin = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_alu", {13'd0, alu_a, alu_b, alu_op}, 32'd0);
    chk("rst_rsp", {6'd0, rsp_err, rsp_cout, rsp_rem, rsp_result}, 32'd0);

    // -5 + 3 and first-command latency
    push(8'hFB, 8'd3, 3'b000, 1'b0);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 3 + LAT);
    chk("add_abs", {16'd0, rsp_result}, 32'h0000FFFE);
    collect("add");

    // back-to-back multiplies, in order
    push(8'd50, 8'd40, 3'b101, 1'b0);
    push(8'hFC, 8'd3, 3'b101, 1'b0);
    chk("mul1_abs", {16'd0, exp_q[0][15:0]}, 32'd2000);
    collect("mul1");
    collect("mul2");

    // -9 / 2
    push(8'hF7, 8'd2, 3'b110, 1'b0);
    collect("div");

    // -9 / 0 leaves ALU inputs alone
    alu_snap = {alu_a, alu_b, alu_op};
    push(8'hF7, 8'd0, 3'b110, 1'b1);
    collect("div0");
    chk("div0_alu", {13'd0, alu_snap}, {13'd0, alu_a, alu_b, alu_op});

    // reserved op
    push(8'd7, 8'd9, 3'b011, 1'b0);
`ifdef ALU_CMD_STATS_EN
    errs0 = stat_errs;
    while (!rsp_valid) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("stat_hold", {16'd0, stat_errs}, {16'd0, errs0});
`endif
    collect("rsvd");
`ifdef ALU_CMD_STATS_EN
    chk("stat_inc", {16'd0, stat_errs}, {16'd0, errs0 + 16'd1});
`endif

    // back-pressure: fill FIFO with one in flight
    for (int i = 0; i <= DEPTH; i++)
      push(8'($urandom), 8'($urandom_range(1, 255)),
           3'b000 + 3'($urandom_range(0, 1)), 1'($urandom));
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("full_ready", {31'd0, cmd_ready}, 32'd0);
    rsp_snap = {rsp_err, rsp_cout, rsp_rem, rsp_result};
    cmd_valid = 1'b1;
    cmd_a = 8'd1; cmd_b = 8'd1; cmd_op = 3'b000; cmd_cin = 1'b0;
    repeat (5) @(negedge clk);
    chk("full_hold", {31'd0, cmd_ready}, 32'd0);
    chk("rsp_stable", {6'd0, rsp_snap},
        {6'd0, rsp_err, rsp_cout, rsp_rem, rsp_result});
    cmd_valid = 1'b0;
    for (int i = 0; i <= DEPTH; i++) collect("fill");
    chk("fill_drain", exp_q.size(), 0);

    // random traffic
    for (int it = 0; it < 30; it++) begin
      int n;
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++)
        push(8'($urandom),
             ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom),
             3'($urandom_range(0, 7)), 1'($urandom));
      for (int k = 0; k < n; k++) collect("rnd");
    end

    // reset during WAIT with queued commands
    push(8'd10, 8'd20, 3'b000, 1'b0);
    push(8'd11, 8'd21, 3'b001, 1'b0);
    push(8'd12, 8'd22, 3'b101, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    rst_n = 1'b1;
    exp_q.delete();
    stale = 0;
    rsp_ready = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid) stale++;
    end
    rsp_ready = 1'b0;
    chk("no_stale", stale, 0);

    // still functional after reset
    push(8'd100, 8'd100, 3'b000, 1'b1);
    collect("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
